// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake plus ALU datapath drive/return for alu_op_sequencer.
// slave = the sequencer; master = requester, consumer and ALU model.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [5:0]  alu_signal;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_signal, alu_dataA, alu_dataB, rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_signal, alu_dataA, alu_dataB, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one op at a time onto the shared ALU/shifter/multiplier/HiLo datapath,
// holds it for the op's latency, samples the result and returns it as a response.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT    = 2,
  parameter int unsigned MUL_CYCLES = 33,
  parameter logic [5:0]  IDLE_OP    = 6'b100000
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_op_sequencer_if.slave    bus
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned DW    = 32;

  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_SLL   = 6'd0;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;

  if (ALU_LAT == 0 || ALU_LAT > 63) begin : g_bad_alu_lat
    $error("ALU_LAT must be in 1..63");
  end
  if (MUL_CYCLES == 0 || MUL_CYCLES > 63) begin : g_bad_mul_cycles
    $error("MUL_CYCLES must be in 1..63");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [DW-1:0]    rsp_data_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic [5:0]       alu_signal_q;
  logic [DW-1:0]    alu_a_q;
  logic [DW-1:0]    alu_b_q;

  logic op_ok_c;
  logic op_mul_c;

  always_comb begin
    op_ok_c  = 1'b0;
    op_mul_c = (bus.req_op == OP_MULTU);
    case (bus.req_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL,
      OP_SLT, OP_MULTU, OP_MFHI, OP_MFLO: op_ok_c = 1'b1;
      default:                            op_ok_c = 1'b0;
    endcase
  end

  // rsp_valid rises one cycle after entering RESP, giving ALU_LAT+1 / MUL_CYCLES+1 / 1 latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mul_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      alu_signal_q <= IDLE_OP;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (op_ok_c) begin
              alu_signal_q <= bus.req_op;
              alu_a_q      <= bus.req_a;
              alu_b_q      <= bus.req_b;
              mul_q        <= op_mul_c;
              cnt_q        <= op_mul_c ? CNT_W'(MUL_CYCLES) : CNT_W'(ALU_LAT);
              state_q      <= ST_RUN;
            end else begin
              rsp_err_q  <= 1'b1;
              rsp_data_q <= '0;
              state_q    <= ST_RESP;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Releasing the datapath exactly here keeps the multiplier from restarting.
          if (cnt_q == CNT_W'(1)) begin
            rsp_data_q   <= mul_q ? '0 : bus.alu_result;
            rsp_err_q    <= 1'b0;
            alu_signal_q <= IDLE_OP;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;
  assign bus.alu_signal = alu_signal_q;
  assign bus.alu_dataA  = alu_a_q;
  assign bus.alu_dataB  = alu_b_q;

endmodule
